// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU-wide constants and types used by the fetch front end.
//   RESET_PC      : PC value loaded after reset
//   INSTR_NOP     : instruction word shown to decode when nothing is queued
//   fetch_state_t : states of the instruction fetch FSM
//   pc_plus4      : sequential PC step, wraps modulo 2^32
//   word_align    : clears the two byte-offset bits of an address
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [31:0] RESET_PC  = 32'h0000_3000;
   localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

   // IDLE  : nothing outstanding at the memory
   // REQ   : request presented, not yet accepted
   // WAIT  : request accepted, response still to come
   // DRAIN : response still to come, but it belongs to a squashed path
   typedef enum logic [1:0] {
      FETCH_IDLE  = 2'd0,
      FETCH_REQ   = 2'd1,
      FETCH_WAIT  = 2'd2,
      FETCH_DRAIN = 2'd3
   } fetch_state_t;

   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Small FIFO of fetched {instruction, pc} pairs sitting between the fetch FSM
// and decode.
//   clk, reset            : clock, synchronous active-high reset
//   push, push_instr/pc   : write one entry (ignored when full)
//   pop                   : drop the head entry (ignored when empty)
//   flush                 : discard every entry
//   full, empty           : occupancy flags
//   head_instr, head_pc   : current head, zero while empty
// -----------------------------------------------------------------------------
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic [31:0] push_instr,
   input  logic [31:0] push_pc,
   input  logic        pop,
   input  logic        flush,
   output logic        full,
   output logic        empty,
   output logic [31:0] head_instr,
   output logic [31:0] head_pc
);

   localparam int PTR_W = $clog2(QDEPTH);
   localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(QDEPTH);

   logic [31:0]    instr_mem [QDEPTH];
   logic [31:0]    pc_mem    [QDEPTH];
   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] rd_ptr;
   logic [PTR_W:0] used;
   logic           do_push;
   logic           do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign used    = wr_ptr - rd_ptr;
   assign full    = (used == DEPTH_CNT);
   assign empty   = (used == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Flush simply rewinds both pointers; stale storage is never visible
   // because the head outputs are masked while empty.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush && !reset) begin
         instr_mem[wr_ptr[PTR_W-1:0]] <= push_instr;
         pc_mem[wr_ptr[PTR_W-1:0]]    <= push_pc;
      end
   end

   assign head_instr = empty ? INSTR_NOP : instr_mem[rd_ptr[PTR_W-1:0]];
   assign head_pc    = empty ? 32'h0     : pc_mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch front end: issues one instruction-memory request at a time from the
// current PC, steps the PC by 4 on acceptance, handles redirects from EX and
// queues returned words for decode.
//   clk, reset                        : clock, synchronous active-high reset
//   pc_cur / pc_next / pc_load        : interface to the external PC register
//   redirect_valid / redirect_pc      : taken branch or jump from EX
//   imem_req_valid/addr/ready         : request channel to instruction memory
//   imem_rsp_valid/data               : response channel from instruction memory
//   id_valid/instr/pc/pc_plus4, id_ready : queue head handed to decode
// -----------------------------------------------------------------------------
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int          QDEPTH   = 2,
   parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_cur,
   output logic [31:0] pc_next,
   output logic        pc_load,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   input  logic        id_ready
);

   fetch_state_t state;
   fetch_state_t state_next;

   logic [31:0] req_addr_q;
   logic        accept;
   logic        push;
   logic        pop;
   logic        flush;
   logic        q_full;
   logic        q_empty;
   logic [31:0] head_instr;
   logic [31:0] head_pc;
   logic        unused_low_bits;

   // Redirect targets are word-aligned, so their byte-offset bits are dropped.
   assign unused_low_bits = ^redirect_pc[1:0];

   // State register; reset forgets any request still in flight.
   always_ff @(posedge clk) begin
      if (reset) state <= FETCH_IDLE;
      else       state <= state_next;
   end

   // The address of the accepted request is kept so the returning word can be
   // tagged with it, because pc_cur has already moved on by then.
   always_ff @(posedge clk) begin
      if (reset)       req_addr_q <= 32'h0;
      else if (accept) req_addr_q <= imem_req_addr;
   end

   // Next-state logic. Only IDLE checks queue space: with a single request
   // outstanding, "queue count + outstanding" reduces to "queue not full".
   always_comb begin
      state_next = state;
      unique case (state)
         FETCH_IDLE: begin
            if (!redirect_valid && !q_full) state_next = FETCH_REQ;
         end
         FETCH_REQ: begin
            if (accept)              state_next = redirect_valid ? FETCH_DRAIN : FETCH_WAIT;
            else if (redirect_valid) state_next = FETCH_IDLE;
         end
         FETCH_WAIT: begin
            if (imem_rsp_valid)      state_next = FETCH_IDLE;
            else if (redirect_valid) state_next = FETCH_DRAIN;
         end
         FETCH_DRAIN: begin
            if (imem_rsp_valid) state_next = FETCH_IDLE;
         end
         default: state_next = FETCH_IDLE;
      endcase
   end

   // Output logic. A redirect accepted together with a request still counts as
   // an acceptance (the response must be drained) but its target beats +4.
   always_comb begin
      imem_req_valid = (state == FETCH_REQ) && !reset;
      imem_req_addr  = word_align(pc_cur);
      accept         = imem_req_valid && imem_req_ready;
      pc_load        = 1'b0;
      pc_next        = pc_plus4(pc_cur);
      push           = 1'b0;
      pop            = 1'b0;
      flush          = 1'b0;
      if (reset) begin
         pc_next = RESET_PC;
      end else begin
         if (redirect_valid) begin
            pc_load = 1'b1;
            pc_next = word_align(redirect_pc);
            flush   = 1'b1;
         end else if (accept) begin
            pc_load = 1'b1;
            pc_next = pc_plus4(pc_cur);
         end
         push = (state == FETCH_WAIT) && imem_rsp_valid && !redirect_valid;
         pop  = !q_empty && id_ready && !redirect_valid;
      end
   end

   fetch_queue #(
      .QDEPTH (QDEPTH)
   ) u_fetch_queue (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_instr (imem_rsp_data),
      .push_pc    (req_addr_q),
      .pop        (pop),
      .flush      (flush),
      .full       (q_full),
      .empty      (q_empty),
      .head_instr (head_instr),
      .head_pc    (head_pc)
   );

   assign id_valid    = !q_empty;
   assign id_instr    = head_instr;
   assign id_pc       = head_pc;
   assign id_pc_plus4 = q_empty ? 32'h0 : pc_plus4(head_pc);

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter QDEPTH, 2: fetch queue entries (power of two, >=2).
REQ-002 Parameter RESET_PC, 32'h00003000: PC value after reset, taken from the shared package.
REQ-003 clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 pc_cur  in  32  current PC from the PC register.
REQ-006 pc_next  out  32  value the PC register loads when pc_load=1.
REQ-007 pc_load  out  1  PC register load strobe.
REQ-008 redirect_valid  in  1  branch/jump taken, from EX.
REQ-009 redirect_pc  in  32  branch/jump target.
REQ-010 imem_req_valid  out  1  fetch request valid.
REQ-011 imem_req_addr  out  32  fetch word address.
REQ-012 imem_req_ready  in  1  memory accepts request.
REQ-013 imem_rsp_valid  in  1  instruction word returned.
REQ-014 imem_rsp_data  in  32  instruction word.
REQ-015 id_valid / id_instr / id_pc / id_pc_plus4  out  1/32/32/32  queue head to decode.
REQ-016 id_ready  in  1  decode accepts head.

Function
REQ-017 FSM states: IDLE (no request outstanding), REQ (imem_req_valid=1, not yet accepted), WAIT (accepted, awaiting response), DRAIN (response outstanding, to be discarded).
REQ-018 IDLE->REQ when no redirect and queue count + outstanding < QDEPTH; imem_req_addr = {pc_cur[31:2],2'b00}.
REQ-019 REQ->WAIT on imem_req_valid & imem_req_ready; the same cycle pc_load=1, pc_next=pc_cur+4 (mod 2^32; 32'hFFFFFFFC wraps to 0).
REQ-020 Address and valid held stable in REQ until accepted, except on redirect.
REQ-021 At most one request outstanding.
REQ-022 WAIT->IDLE on imem_rsp_valid; push {imem_rsp_data, request addr} into queue; id_valid rises the following cycle (minimum fetch-to-decode latency 2 cycles from acceptance).
REQ-023 id_pc_plus4 = id_pc + 4, same wrap rule.
REQ-024 Pop queue on id_valid & id_ready; push and pop in the same cycle on a non-empty queue keep the count unchanged.
REQ-025 Queue full: no new request issued; state stays IDLE until a pop.
REQ-026 Redirect (any state): flush queue (id_valid=0 next cycle), pc_load=1, pc_next={redirect_pc[31:2],2'b00}; no request issued that cycle.
REQ-027 Redirect in REQ without acceptance: withdraw request, go IDLE.
REQ-028 Redirect in WAIT, or in REQ coincident with acceptance: go DRAIN; the redirect pc_next wins over +4.
REQ-029 DRAIN->IDLE on imem_rsp_valid, response discarded.
REQ-030 Redirect coincident with imem_rsp_valid in WAIT: response discarded, go IDLE.
REQ-031 imem_rsp_valid in IDLE or REQ is ignored.
REQ-032 pc_load=0 in every cycle not covered by REQ-019/REQ-026.

Reset
REQ-033 On reset: state IDLE, queue empty, id_valid=0, imem_req_valid=0, pc_load=0, pc_next=RESET_PC, id_instr/id_pc/id_pc_plus4=0.
REQ-034 Reset mid-operation overrides redirect and handshakes; outstanding requests are forgotten; the first request issues no earlier than the cycle after reset deasserts.

Structure
REQ-035 Package cpu_pkg holds RESET_PC, the fetch FSM state enum, and INSTR_NOP=32'h00000000.
REQ-036 Sub-module fetch_queue: QDEPTH-entry FIFO of {instr[31:0], pc[31:0]} with push, pop, flush, full, empty.
REQ-037 The FSM and PC arithmetic stay in instr_fetch_unit.

Verification
REQ-038 Reset release, pc_cur=32'h3000, ready=1, 1-cycle memory -> request addr 3000, pc_next=3004 with pc_load, id_pc=3000 two cycles after acceptance.
REQ-039 id_ready=0, streaming fetch -> exactly 2 entries queued, imem_req_valid stays 0 until pop.
REQ-040 imem_req_ready=0 for 3 cycles -> addr held stable, pc_load=0 until acceptance.
REQ-041 Redirect to 32'h4000 while in WAIT -> DRAIN, late response dropped, next id_pc=4000.
REQ-042 pc_cur=32'hFFFFFFFC -> pc_next=0, id_pc_plus4=0.
REQ-043 Reset asserted in WAIT with queue holding 1 entry -> id_valid=0 next cycle, a later stray rsp_valid is ignored.
